mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM-stage controller that consumes the EX/MEM pipeline register outputs.
- Drives a multi-cycle data memory through a request/valid handshake and holds the upstream pipeline with a stall while an access is outstanding.
- Registers the MEM/WB pipeline outputs: ALU result, load data, writeback controls, halt.
- Non-memory instructions pass through with one-cycle latency and no stall.

Parameters:
- MAX_WAIT, 15, maximum BUSY cycles allowed before the memory-timeout error flag sets (range 1..255).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- ex_alu_result  input  16  EX/MEM ALU result; used as memory address and as passthrough data.
- ex_sw_data  input  16  store data.
- ex_mem_write  input  1  store instruction.
- ex_mem_read  input  1  load instruction.
- ex_mem_to_reg  input  1  writeback mux select.
- ex_reg_write  input  1  writeback enable.
- ex_hlt  input  1  halt instruction.
- ex_dst_reg  input  4  destination register.
- mem_en  output  1  one-cycle memory request strobe.
- mem_wr  output  1  request is a write; meaningful only while mem_en=1.
- mem_addr  output  16  request address.
- mem_wdata  output  16  request write data.
- mem_rdata  input  16  read data; sampled only when mem_data_valid=1.
- mem_data_valid  input  1  one-cycle completion pulse for a read or a write.
- stall  output  1  combinational; when 1, EX/MEM and all earlier stages hold.
- wb_alu_result  output  16  registered.
- wb_mem_data  output  16  registered load data.
- wb_mem_to_reg  output  1  registered.
- wb_reg_write  output  1  registered.
- wb_hlt  output  1  registered.
- wb_dst_reg  output  4  registered.
- mem_err  output  1  sticky timeout flag.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, wait counter=0.
  - All wb_* outputs=0, mem_err=0, mem_en=0.
  - stall follows its combinational equation with state=IDLE.
- States: IDLE, BUSY.
- access = ex_mem_read | ex_mem_write. If both are 1, the access is treated as a write (mem_wr=1) and read data is not captured.
- IDLE, access=0:
  - stall=0, mem_en=0.
  - Next edge loads wb_* from ex_* and sets wb_mem_data=0.
  - State stays IDLE.
- IDLE, access=1:
  - mem_en=1 combinationally in this cycle.
  - mem_wr=ex_mem_write, mem_addr=ex_alu_result, mem_wdata=ex_sw_data.
  - stall=1.
  - Next edge: state→BUSY, counter→1, wb_* loaded with a bubble (wb_reg_write=0, wb_hlt=0; other fields 0).
- BUSY, mem_data_valid=0:
  - mem_en=0, stall=1.
  - Bubble into wb_* each edge.
  - counter increments, saturating at 255.
  - When counter reaches MAX_WAIT, mem_err sets; the block keeps waiting.
- BUSY, mem_data_valid=1:
  - stall=0 in this same cycle.
  - Next edge: wb_* loaded from ex_* (still held), wb_mem_data=mem_rdata if it is a read, otherwise 0.
  - State→IDLE, counter→0.
  - The upstream pipeline advances on the same edge, so the next instruction is seen in IDLE with no reissue.
- mem_data_valid while IDLE is ignored (covers a stale response after a reset mid-access).
- Latency:
  - Non-memory instruction: 1 cycle.
  - Memory instruction: 1 + N cycles, where N is the number of BUSY cycles up to and including the valid cycle.
- mem_en is never 1 in two consecutive cycles. At most one request is outstanding.
- ex_hlt with access=0 passes through like any other instruction. A halt is never issued to memory.
- mem_err clears only on reset.

Test Plan:
- Reset → release with ex_reg_write=1, ex_alu_result=16'h1234, ex_dst_reg=4'h3, no access → one edge later wb_alu_result=16'h1234, wb_reg_write=1, wb_dst_reg=3; stall=0 throughout.
- Load at addr 16'h0040, memory returns 16'hBEEF with mem_data_valid 3 cycles after mem_en:
  - mem_en high exactly 1 cycle with mem_wr=0, mem_addr=16'h0040.
  - stall high 3 cycles, bubbles in wb_*.
  - Then wb_mem_data=16'hBEEF, wb_mem_to_reg=1, wb_reg_write=1.
- Store 16'h00AA to 16'h0010 followed immediately by an ADD:
  - mem_en=1, mem_wr=1, mem_wdata=16'h00AA.
  - Upstream frozen until valid; ADD reaches wb_* exactly one edge after the store completes.
  - No second mem_en.
- ex_mem_read=1 and ex_mem_write=1 together → mem_wr=1; after completion wb_mem_data=0.
- MAX_WAIT=4, mem_data_valid withheld → mem_err=1 on the 4th BUSY edge; a later valid completes normally and mem_err stays 1.
- Assert rst 2 cycles into BUSY, then pulse mem_data_valid after release → state IDLE, all wb_*=0, no mem_en, stale valid ignored.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues one data-memory request per load/store,
// stalls the upstream pipeline until the memory signals completion, and
// registers the MEM/WB pipeline outputs. Non-memory instructions take one
// cycle and never stall.
module mem_access_stage #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ex_alu_result,
  input  logic [15:0] ex_sw_data,
  input  logic        ex_mem_write,
  input  logic        ex_mem_read,
  input  logic        ex_mem_to_reg,
  input  logic        ex_reg_write,
  input  logic        ex_hlt,
  input  logic [3:0]  ex_dst_reg,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_data_valid,
  output logic        stall,
  output logic [15:0] wb_alu_result,
  output logic [15:0] wb_mem_data,
  output logic        wb_mem_to_reg,
  output logic        wb_reg_write,
  output logic        wb_hlt,
  output logic [3:0]  wb_dst_reg,
  output logic        mem_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);
  localparam logic [7:0] WAIT_SAT   = 8'd255;

  state_t     state, state_next;
  logic [7:0] wait_cnt, wait_cnt_next;
  logic       access;
  logic       load_ex;
  logic       err_set;
  logic       capture_rdata;

  // A simultaneous read+write is handled as a write; read data is dropped.
  assign access        = ex_mem_read | ex_mem_write;
  assign capture_rdata = ex_mem_read & ~ex_mem_write;

  // The request bus mirrors EX/MEM; only mem_en qualifies it.
  assign mem_wr    = ex_mem_write;
  assign mem_addr  = ex_alu_result;
  assign mem_wdata = ex_sw_data;

  // Next-state, request strobe, stall and MEM/WB load decision.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case can leave a value unassigned and infer a latch.
    state_next    = state;
    wait_cnt_next = wait_cnt;
    mem_en        = 1'b0;
    stall         = 1'b0;
    load_ex       = 1'b0;
    err_set       = 1'b0;
    unique case (state)
      IDLE: begin
        if (access) begin
          mem_en        = 1'b1;
          stall         = 1'b1;
          state_next    = BUSY;
          wait_cnt_next = 8'd1;
        end else begin
          load_ex = 1'b1;
        end
      end
      BUSY: begin
        if (mem_data_valid) begin
          load_ex       = 1'b1;
          state_next    = IDLE;
          wait_cnt_next = 8'd0;
        end else begin
          stall = 1'b1;
          if (wait_cnt != WAIT_SAT) wait_cnt_next = wait_cnt + 8'd1;
          // wait_cnt equals the index of the current BUSY cycle, so the
          // flag sets on the edge that ends the MAX_WAIT-th waiting cycle.
          if (wait_cnt >= WAIT_LIMIT) err_set = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Control state, wait counter and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of evaluation order.
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (err_set) mem_err <= 1'b1;
    end
  end

  // MEM/WB pipeline register: EX/MEM contents when the stage advances,
  // a bubble while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_alu_result <= 16'd0;
      wb_mem_data   <= 16'd0;
      wb_mem_to_reg <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_hlt        <= 1'b0;
      wb_dst_reg    <= 4'd0;
    end else if (load_ex) begin
      wb_alu_result <= ex_alu_result;
      wb_mem_data   <= (state == BUSY && capture_rdata) ? mem_rdata : 16'd0;
      wb_mem_to_reg <= ex_mem_to_reg;
      wb_reg_write  <= ex_reg_write;
      wb_hlt        <= ex_hlt;
      wb_dst_reg    <= ex_dst_reg;
    end else begin
      wb_alu_result <= 16'd0;
      wb_mem_data   <= 16'd0;
      wb_mem_to_reg <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_hlt        <= 1'b0;
      wb_dst_reg    <= 4'd0;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: a driver issues directed
// instructions and queues the expected MEM/WB contents; a monitor pops and
// compares whenever the stage advances; a memory responder answers requests
// with a programmed latency.
module tb_mem_access_stage;

  typedef struct packed {
    logic [15:0] alu;
    logic [15:0] mem_data;
    logic        to_reg;
    logic        reg_write;
    logic        hlt;
    logic [3:0]  dst;
  } wb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ex_alu_result = '0;
  logic [15:0] ex_sw_data = '0;
  logic        ex_mem_write = 1'b0;
  logic        ex_mem_read = 1'b0;
  logic        ex_mem_to_reg = 1'b0;
  logic        ex_reg_write = 1'b0;
  logic        ex_hlt = 1'b0;
  logic [3:0]  ex_dst_reg = '0;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_data_valid = 1'b0;
  logic        stall;
  logic [15:0] wb_alu_result, wb_mem_data;
  logic        wb_mem_to_reg, wb_reg_write, wb_hlt;
  logic [3:0]  wb_dst_reg;
  logic        mem_err;

  int n_checks = 0;
  int n_pass   = 0;
  wb_t sb[$];

  // Responder programming (written by the driver only).
  int          mem_lat = 0;
  logic [15:0] resp_data = '0;
  logic [15:0] manual_data = '0;
  int          manual_req = 0;
  logic        exp_wr = 1'b0;
  logic [15:0] exp_addr = '0;
  logic [15:0] exp_wdata = '0;
  int          en_count = 0;

  mem_access_stage #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .ex_alu_result(ex_alu_result), .ex_sw_data(ex_sw_data),
    .ex_mem_write(ex_mem_write), .ex_mem_read(ex_mem_read),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
    .ex_hlt(ex_hlt), .ex_dst_reg(ex_dst_reg),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_data_valid(mem_data_valid), .stall(stall),
    .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write),
    .wb_hlt(wb_hlt), .wb_dst_reg(wb_dst_reg), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic wb_t wb_now();
    return '{wb_alu_result, wb_mem_data, wb_mem_to_reg, wb_reg_write, wb_hlt, wb_dst_reg};
  endfunction

  // Monitor: after an edge where stall was low the MEM/WB register holds the
  // next instruction; after a stalled edge it must hold a bubble.
  logic mon_armed = 1'b0;
  logic mon_stalled = 1'b0;
  always begin
    @(negedge clk);
    if (rst) begin
      mon_armed = 1'b0;
    end else begin
      if (mon_armed) begin
        if (mon_stalled) begin
          check("wb_bubble", 64'(wb_now()), 64'd0);
        end else if (sb.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          check("wb_result", 64'(wb_now()), 64'(sb.pop_front()));
        end
      end
      mon_armed   = 1'b1;
      mon_stalled = stall;
    end
  end

  // Memory responder: checks each request, then pulses mem_data_valid
  // mem_lat cycles later (mem_lat=0 withholds it); manual pulses on demand.
  int   resp_cnt = 0;
  int   manual_ack = 0;
  logic prev_en = 1'b0;
  logic en_seen;
  always begin
    @(negedge clk);
    en_seen = mem_en && !rst;
    if (en_seen) begin
      en_count++;
      check("req_back_to_back", 64'(prev_en), 64'd0);
      check("req_wr", 64'(mem_wr), 64'(exp_wr));
      check("req_addr", 64'(mem_addr), 64'(exp_addr));
      if (exp_wr) check("req_wdata", 64'(mem_wdata), 64'(exp_wdata));
    end
    prev_en = en_seen;
    @(posedge clk);
    #1;
    mem_data_valid = 1'b0;
    if (rst) begin
      resp_cnt = 0;
    end else begin
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          mem_data_valid = 1'b1;
          mem_rdata      = resp_data;
        end
      end
      if (en_seen && mem_lat > 0) begin
        if (mem_lat == 1) begin
          mem_data_valid = 1'b1;
          mem_rdata      = resp_data;
        end else begin
          resp_cnt = mem_lat - 1;
        end
      end
    end
    if (manual_req != manual_ack) begin
      mem_data_valid = 1'b1;
      mem_rdata      = manual_data;
      manual_ack     = manual_req;
    end
  end

  // Drive one instruction (called at posedge+1), queue its expected MEM/WB
  // image and hold it until the stage accepts it; count stalled cycles.
  task automatic issue(input logic rd, input logic wr, input logic to_reg,
                       input logic rw, input logic hlt, input logic [15:0] alu,
                       input logic [15:0] sw, input logic [3:0] dst,
                       input logic [15:0] exp_md, input int exp_stalls);
    int stalls = 0;
    bit done = 0;
    ex_mem_read = rd; ex_mem_write = wr; ex_mem_to_reg = to_reg;
    ex_reg_write = rw; ex_hlt = hlt; ex_alu_result = alu;
    ex_sw_data = sw; ex_dst_reg = dst;
    sb.push_back('{alu, exp_md, to_reg, rw, hlt, dst});
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (stall) stalls++;
      else done = 1;
    end
    if (!done) check("accept_timeout", 64'd1, 64'd0);
    else check("stall_cycles", 64'(stalls), 64'(exp_stalls));
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    ex_mem_read = 0; ex_mem_write = 0; ex_mem_to_reg = 0; ex_reg_write = 0;
    ex_hlt = 0; ex_alu_result = '0; ex_sw_data = '0; ex_dst_reg = '0;
  endtask

  int en_snap;

  initial begin
    // Reset state with idle inputs.
    #12;
    check("rst_wb", 64'(wb_now()), 64'd0);
    check("rst_mem_err", 64'(mem_err), 64'd0);
    check("rst_mem_en", 64'(mem_en), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    @(negedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;

    // Plain ALU instruction passes through with no stall.
    issue(0, 0, 0, 1, 0, 16'h1234, 16'h0, 4'h3, 16'h0, 0);

    // Load, memory answers 3 cycles after the request.
    mem_lat = 3; resp_data = 16'hBEEF; exp_wr = 0; exp_addr = 16'h0040;
    issue(1, 0, 1, 1, 0, 16'h0040, 16'h0, 4'h5, 16'hBEEF, 3);

    // Store followed immediately by an ADD: exactly one request.
    en_snap = en_count;
    mem_lat = 2; resp_data = 16'h9999; exp_wr = 1; exp_addr = 16'h0010;
    exp_wdata = 16'h00AA;
    issue(0, 1, 0, 0, 0, 16'h0010, 16'h00AA, 4'h0, 16'h0, 2);
    issue(0, 0, 0, 1, 0, 16'h0077, 16'h0, 4'h7, 16'h0, 0);
    check("store_single_req", 64'(en_count - en_snap), 64'd1);

    // Read and write together: treated as a write, no data captured.
    mem_lat = 1; resp_data = 16'hDEAD; exp_wr = 1; exp_addr = 16'h0020;
    exp_wdata = 16'h5555;
    issue(1, 1, 1, 1, 0, 16'h0020, 16'h5555, 4'h9, 16'h0, 1);

    // Halt passes through without touching memory.
    en_snap = en_count;
    issue(0, 0, 0, 0, 1, 16'h0ABC, 16'h0, 4'h2, 16'h0, 0);
    check("hlt_no_req", 64'(en_count - en_snap), 64'd0);
    check("no_err_yet", 64'(mem_err), 64'd0);

    // Timeout: valid withheld past 4 BUSY cycles, then a late completion.
    mem_lat = 0; exp_wr = 0; exp_addr = 16'h0030; manual_data = 16'h1111;
    fork
      issue(1, 0, 1, 1, 0, 16'h0030, 16'h0, 4'h2, 16'h1111, 6);
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("err_before_4th_edge", 64'(mem_err), 64'd0);
        @(negedge clk);
        check("err_after_4th_edge", 64'(mem_err), 64'd1);
        manual_req++;
      end
    join
    issue(0, 0, 0, 1, 0, 16'h0042, 16'h0, 4'h4, 16'h0, 0);
    check("err_sticky", 64'(mem_err), 64'd1);

    // Reset two cycles into BUSY, then a stale valid after release.
    exp_wr = 0; exp_addr = 16'h0050;
    ex_mem_read = 1; ex_reg_write = 1; ex_mem_to_reg = 1;
    ex_alu_result = 16'h0050; ex_dst_reg = 4'h6;
    @(posedge clk); @(posedge clk); @(posedge clk);
    #3 rst = 1'b1;
    drive_idle();
    sb.delete();
    #1;
    check("midrst_wb", 64'(wb_now()), 64'd0);
    check("midrst_err", 64'(mem_err), 64'd0);
    check("midrst_mem_en", 64'(mem_en), 64'd0);
    @(negedge clk); #2 rst = 1'b0;
    en_snap = en_count;
    manual_data = 16'hF00D;
    manual_req++;
    @(posedge clk); #1;
    issue(0, 0, 0, 1, 0, 16'h00CC, 16'h0, 4'h1, 16'h0, 0);
    issue(0, 0, 0, 1, 0, 16'h00DD, 16'h0, 4'h8, 16'h0, 0);
    check("stale_valid_no_req", 64'(en_count - en_snap), 64'd0);

    @(negedge clk); #1;
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
